io_input_ctrl: RTL and testbench
================================

# io_input_ctrl

Memory-mapped input peripheral that sits on the core's load/store bus and is the receiving end of the switch and button lines driven by the bench driver. It synchronises `i_io_sw`, synchronises and debounces `i_io_btn`, and latches sticky press events. Software reads these through four word registers, and a registered interrupt signals pending presses.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive cycles a synchronised button level must differ from the stable level before it is accepted. Legal range 2..2^20.
- `BTN_W`, default 4: number of buttons used, taken from `i_io_btn[BTN_W-1:0]`.
- `BTN_ACT_LOW`, default 1: 1 means a raw 0 on a button pin is "pressed".

Ports:
- `i_clk`, input, 1: single clock; all state changes on its rising edge.
- `i_rst_n`, input, 1: reset, asynchronous and active-low.
- `i_io_sw`, input, 32: raw switches, asynchronous to `i_clk`.
- `i_io_btn`, input, 32: raw buttons; bits above `BTN_W-1` are ignored.
- `i_lsu_addr`, input, 4: byte offset; bits [3:2] select the register, bits [1:0] are ignored.
- `i_lsu_wr`, input, 1: write strobe, one cycle per store.
- `i_lsu_wdata`, input, 32: store data.
- `o_lsu_rdata`, output, 32: read data, combinational from registered state and `i_lsu_addr`.
- `o_irq`, output, 1: registered interrupt request.

## Operation
- Register map, word offsets:
  - 0x0 `SW`: synchronised switches. Read-only.
  - 0x4 `BTN`: debounced pressed levels in [BTN_W-1:0], 1 = pressed; upper bits read 0. Read-only.
  - 0x8 `EDGE`: sticky press flags. Write-1-to-clear per bit.
  - 0xC `CTRL`: bit0 = irq enable, bits [BTN_W+3:4] = per-button irq mask. Read/write; other bits read 0 and ignore writes.
- Writes to `SW` and `BTN` are ignored.
- Switch path: 2-flop synchroniser only, no debounce.
- Button path, per bit:
  - 2-flop synchroniser, then invert when `BTN_ACT_LOW`=1, giving `s2`.
  - A counter of width clog2(`DEBOUNCE_CYCLES`) compares `s2` against `stable`:
    - `s2` == `stable`: count <= 0.
    - `s2` != `stable` and count < `DEBOUNCE_CYCLES`-1: count <= count+1.
    - `s2` != `stable` and count == `DEBOUNCE_CYCLES`-1: `stable` <= `s2`, count <= 0.
  - Any single agreeing cycle restarts the count (glitch rejection).
- Press event: `stable` transitions 0 -> 1 on an edge; this sets the matching `EDGE` bit. Release events do not set flags.
- EDGE clear: a write to 0x8 clears the bits where `i_lsu_wdata` is 1. When set and clear hit the same bit on the same edge, set wins and the bit stays 1.
- `o_irq` <= CTRL[0] & |(EDGE & CTRL mask), registered from the current register values each edge.
- Reads have no side effects. An unmapped offset is impossible because all four offsets are decoded.

## Timing
- Reset values:
  - Synchroniser flops hold the released level: 1 per button bit when `BTN_ACT_LOW`=1, else 0. Switch synchronisers hold 0.
  - `stable`, counters, `EDGE`, `CTRL`, `o_irq` are 0.
  - `o_lsu_rdata` therefore reads 0 for every offset during and after reset.
- Switch latency: a value sampled at edge k is readable in `SW` after edge k+1.
- Button latency: a new raw level first sampled at edge k and held updates `stable` at edge k+1+`DEBOUNCE_CYCLES`. The `EDGE` bit sets at that same edge, and `o_irq` rises at edge k+2+`DEBOUNCE_CYCLES`.
- Writes take effect at the edge where `i_lsu_wr`=1. A read in the following cycle returns the new value.
- After an `EDGE` clear, `o_irq` falls one edge after `EDGE` goes to 0.
- Reset asserted mid-debounce or with flags pending: all state returns to its reset value immediately (asynchronous), and any partial count is discarded.
- After reset deasserts, a button already held pressed is accepted after the full synchroniser plus debounce latency, and generates a press event.

## Test plan
Directed scenarios use `DEBOUNCE_CYCLES`=4, `BTN_W`=4, `BTN_ACT_LOW`=1.
- Reset: hold `i_rst_n`=0 with random inputs. `o_lsu_rdata` is 0 at offsets 0x0/0x4/0x8/0xC and `o_irq`=0.
- Switches: drive `i_io_sw`=0xDEAD_BEEF at edge k. A read of 0x0 returns 0xDEAD_BEEF after edge k+1, and still returns the old value before it.
- Clean press: set `i_io_btn`[2]=0 and hold. `BTN` reads 0x4 and `EDGE` reads 0x4 from edge k+5. With `CTRL`=0x41, `o_irq` rises at edge k+6.
- Bounce: toggle `i_io_btn`[0] 0/1 every 2 cycles for 20 cycles, then hold 1. `BTN` and `EDGE` remain 0 throughout.
- W1C plus collision:
  - Write 0x8 with 0x1 while the bit0 press event fires on the same edge: `EDGE`[0] stays 1.
  - A later write of 0x1: `EDGE` reads 0, and `o_irq` falls one edge later.
- Reset mid-operation: pulse `i_rst_n` low with 3 of 4 debounce cycles elapsed and `EDGE`=0xF. All registers read 0. A held press is re-accepted 6 edges after release of reset.

Source files
------------

// File: rtl/io_input_ctrl.sv
// Memory-mapped switch/button input block: synchronisers, debounce,
// sticky press flags and a registered interrupt.
module io_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int BTN_W           = 4,
    parameter bit BTN_ACT_LOW     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_io_sw,
    input  logic [31:0] i_io_btn,
    input  logic [3:0]  i_lsu_addr,
    input  logic        i_lsu_wr,
    input  logic [31:0] i_lsu_wdata,
    output logic [31:0] o_lsu_rdata,
    output logic        o_irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BTN_W-1:0] BTN_IDLE = {BTN_W{BTN_ACT_LOW}};

    logic [31:0]      sw_meta;
    logic [31:0]      sw_sync;
    logic [BTN_W-1:0] btn_meta;
    logic [BTN_W-1:0] btn_sync;
    logic [BTN_W-1:0] s2;
    logic [BTN_W-1:0] stable;
    logic [CW-1:0]    cnt [BTN_W];
    logic [BTN_W-1:0] accept;
    logic [BTN_W-1:0] press;
    logic [BTN_W-1:0] edge_flags;
    logic [BTN_W-1:0] edge_clr;
    logic             ctrl_en;
    logic [BTN_W-1:0] ctrl_mask;
    logic             wr_edge;
    logic             wr_ctrl;
    logic [31:0]      rdata;
    logic             irq;
    logic             unused_ok;

    // Raw pins are sampled as-is; polarity is normalised after the sync.
    assign s2 = btn_sync ^ BTN_IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= BTN_IDLE;
            btn_sync <= BTN_IDLE;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn[BTN_W-1:0];
            btn_sync <= btn_meta;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < BTN_W; i++) begin
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign press    = accept & s2;
    assign wr_edge  = i_lsu_wr && (i_lsu_addr[3:2] == 2'd2);
    assign wr_ctrl  = i_lsu_wr && (i_lsu_addr[3:2] == 2'd3);
    assign edge_clr = wr_edge ? i_lsu_wdata[BTN_W-1:0] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable <= '0;
            for (int i = 0; i < BTN_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BTN_W; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press landing on the same edge as its clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            edge_flags <= '0;
            ctrl_en    <= 1'b0;
            ctrl_mask  <= '0;
            irq        <= 1'b0;
        end else begin
            edge_flags <= (edge_flags & ~edge_clr) | press;
            if (wr_ctrl) begin
                ctrl_en   <= i_lsu_wdata[0];
                ctrl_mask <= i_lsu_wdata[BTN_W+3:4];
            end
            irq <= ctrl_en & |(edge_flags & ctrl_mask);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (i_lsu_addr[3:2])
            2'd0: rdata = sw_sync;
            2'd1: rdata[BTN_W-1:0] = stable;
            2'd2: rdata[BTN_W-1:0] = edge_flags;
            2'd3: begin
                rdata[0]         = ctrl_en;
                rdata[BTN_W+3:4] = ctrl_mask;
            end
        endcase
    end

    assign o_lsu_rdata = rdata;
    assign o_irq       = irq;
    assign unused_ok   = ^{i_io_btn, i_lsu_addr[1:0], i_lsu_wdata};

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed scoreboard bench for io_input_ctrl with a short
// debounce window.
module tb_io_input_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] io_sw;
    logic [31:0] io_btn;
    logic [3:0]  lsu_addr;
    logic        lsu_wr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    io_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BTN_W(4),
        .BTN_ACT_LOW(1'b1)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_io_sw(io_sw),
        .i_io_btn(io_btn),
        .i_lsu_addr(lsu_addr),
        .i_lsu_wr(lsu_wr),
        .i_lsu_wdata(lsu_wdata),
        .o_lsu_rdata(lsu_rdata),
        .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed=0x%08h with no expected value", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h",
                       tag, obs, e);
            end
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] addr,
                      input logic [31:0] exp);
        exp_q.push_back(exp);
        lsu_addr = addr;
        #1;
        check(tag, lsu_rdata);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        exp_q.push_back({31'b0, exp});
        #1;
        check(tag, {31'b0, irq});
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        lsu_addr  = addr;
        lsu_wdata = data;
        lsu_wr    = 1'b1;
        @(negedge clk);
        lsu_wr    = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        io_sw     = $urandom;
        io_btn    = $urandom;
        lsu_addr  = 4'h0;
        lsu_wr    = 1'b0;
        lsu_wdata = $urandom;
        step(3);
        rd("rst_sw", 4'h0, 32'h0);
        rd("rst_btn", 4'h4, 32'h0);
        rd("rst_edge", 4'h8, 32'h0);
        rd("rst_ctrl", 4'hC, 32'h0);
        step(1);
        irq_chk("rst_irq", 1'b0);
        io_sw  = 32'h0;
        io_btn = 32'hFFFF_FFFF;
        step(2);
        rst_n = 1'b1;
        step(3);

        // Switch latency and read-only registers
        io_sw = 32'hDEAD_BEEF;
        step(1);
        rd("sw_early", 4'h0, 32'h0);
        step(1);
        rd("sw_new", 4'h0, 32'hDEAD_BEEF);
        wr(4'h0, 32'h1234_5678);
        wr(4'h4, 32'hFFFF_FFFF);
        rd("sw_ro", 4'h1, 32'hDEAD_BEEF);
        rd("btn_ro", 4'h4, 32'h0);

        wr(4'hC, 32'hFFFF_FFFF);
        rd("ctrl_bits", 4'hC, 32'h0000_00F1);
        wr(4'hC, 32'h0000_0041);
        rd("ctrl_41", 4'hD, 32'h0000_0041);

        // Clean press of button 2
        io_btn = 32'hFFFF_FFFB;
        step(5);
        rd("press_btn_k4", 4'h4, 32'h0);
        rd("press_edge_k4", 4'h8, 32'h0);
        step(1);
        rd("press_btn_k5", 4'h4, 32'h4);
        rd("press_edge_k5", 4'h8, 32'h4);
        irq_chk("press_irq_k5", 1'b0);
        step(1);
        irq_chk("press_irq_k6", 1'b1);

        wr(4'h8, 32'h0000_0004);
        rd("clr_edge", 4'h8, 32'h0);
        irq_chk("clr_irq_same", 1'b1);
        step(1);
        irq_chk("clr_irq_next", 1'b0);

        io_btn = 32'hFFFF_FFFF;
        step(8);
        rd("release_btn", 4'h4, 32'h0);
        rd("release_edge", 4'h8, 32'h0);

        // Bounce on button 0 never reaches the debounce window
        for (int i = 0; i < 5; i++) begin
            io_btn[0] = 1'b0;
            step(2);
            rd("bounce_btn_lo", 4'h4, 32'h0);
            io_btn[0] = 1'b1;
            step(2);
            rd("bounce_btn_hi", 4'h4, 32'h0);
            rd("bounce_edge", 4'h8, 32'h0);
        end
        step(8);
        rd("bounce_btn_end", 4'h4, 32'h0);
        rd("bounce_edge_end", 4'h8, 32'h0);

        // Clear colliding with the press event: set wins
        wr(4'hC, 32'h0000_00F1);
        io_btn = 32'hFFFF_FFFE;
        step(5);
        rd("coll_edge_pre", 4'h8, 32'h0);
        wr(4'h8, 32'h0000_0001);
        rd("coll_edge", 4'h8, 32'h1);
        rd("coll_btn", 4'h4, 32'h1);
        irq_chk("coll_irq_k5", 1'b0);
        step(1);
        irq_chk("coll_irq_k6", 1'b1);
        wr(4'h8, 32'h0000_0001);
        rd("w1c_edge", 4'h8, 32'h0);
        irq_chk("w1c_irq_same", 1'b1);
        step(1);
        irq_chk("w1c_irq_next", 1'b0);

        io_btn = 32'hFFFF_FFFF;
        step(8);
        rd("rel0_edge", 4'h8, 32'h0);
        io_btn = 32'hFFFF_FFF0;
        step(6);
        rd("all_edge", 4'h8, 32'hF);
        rd("all_btn", 4'h4, 32'hF);
        step(1);
        irq_chk("all_irq", 1'b1);

        // Reset with a release 3 cycles into its debounce window
        io_btn = 32'hFFFF_FFFF;
        step(5);
        rd("mid_btn", 4'h4, 32'hF);
        rst_n  = 1'b0;
        io_btn = 32'hFFFF_FFF0;
        rd("mid_rst_sw", 4'h0, 32'h0);
        rd("mid_rst_btn", 4'h4, 32'h0);
        rd("mid_rst_edge", 4'h8, 32'h0);
        rd("mid_rst_ctrl", 4'hC, 32'h0);
        irq_chk("mid_rst_irq", 1'b0);
        step(2);
        rst_n = 1'b1;
        step(5);
        rd("reacc_btn_r5", 4'h4, 32'h0);
        step(1);
        rd("reacc_btn_r6", 4'h4, 32'hF);
        rd("reacc_edge_r6", 4'h8, 32'hF);
        step(1);
        irq_chk("reacc_irq_off", 1'b0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected values left", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
